lfsr_checker: RTL and testbench

- Receive-side partner of the team's 8-bit LFSR generator.
- Consumes the generator's 8-bit output stream, self-synchronises to it using the same tap mask, and then checks every following sample against the locally predicted value.
- Reports lock status, per-sample error pulses and saturating error/sample counters for the AXI-Lite register block.
- Used for loopback/BIST of any datapath carrying the pseudo-random stream.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_sat_counter.sv | 35 +++
 rtl/lfsr_checker.sv | 133 +++++++++++++
 tb/tb_lfsr_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator/checker pair.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

  // One LFSR step: new parity bit enters at the MSB, the rest shift toward the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return {^(s & taps), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear first, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the generator stream,
// then free-runs its prediction and flags every mismatching sample.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [LFSR_W-1:0] taps,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  sample_count,
  output logic [1:0]        state_o
);

  lfsr_state_e       state_q, state_d;
  logic [LFSR_W-1:0] ref_q, ref_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        consec_err_q, consec_err_d;
  logic              err_pulse_q, err_pulse_d;
  logic [LFSR_W-1:0] exp_data;
  logic              hit;
  logic              err_inc;
  logic              sample_inc;

  assign exp_data = lfsr_next(ref_q, taps);
  assign hit      = (in_data == exp_data);

  // FSM next-state, reference update and event generation.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d      = state_q;
    ref_d        = ref_q;
    match_cnt_d  = match_cnt_q;
    consec_err_d = consec_err_q;
    err_pulse_d  = 1'b0;
    err_inc      = 1'b0;
    sample_inc   = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          ref_d       = in_data;
          match_cnt_d = '0;
          state_d     = ST_SYNC;
        end
        ST_SYNC: begin
          ref_d = in_data;
          // An all-zero sample never counts toward lock: the zero state is a fixed point.
          if (hit && (in_data != '0)) begin
            match_cnt_d = match_cnt_q + 4'd1;
          end else begin
            match_cnt_d = '0;
          end
          if (match_cnt_d == 4'(LOCK_COUNT)) begin
            state_d      = ST_LOCKED;
            consec_err_d = '0;
          end
        end
        ST_LOCKED: begin
          sample_inc = 1'b1;
          // Flywheel: the prediction advances whatever was received.
          ref_d      = exp_data;
          if (hit) begin
            consec_err_d = '0;
          end else begin
            err_pulse_d  = 1'b1;
            err_inc      = 1'b1;
            consec_err_d = consec_err_q + 4'd1;
          end
          if (consec_err_d == 4'(LOSS_COUNT)) begin
            state_d     = ST_SYNC;
            ref_d       = in_data;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, reference and per-sample bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ref_q        <= '0;
      match_cnt_q  <= '0;
      consec_err_q <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ref_q        <= ref_d;
      match_cnt_q  <= match_cnt_d;
      consec_err_q <= consec_err_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (err_inc),
    .count (err_count)
  );

  lfsr_sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (sample_inc),
    .count (sample_count)
  );

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker, plus a narrow-counter instance for saturation.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [7:0]  taps;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        locked, err_pulse;
  logic [15:0] err_count, sample_count;
  logic [1:0]  state_o;

  logic        s_locked, s_err_pulse;
  logic [3:0]  s_err_count, s_sample_count;
  logic [1:0]  s_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .taps         (taps),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .sample_count (sample_count),
    .state_o      (state_o)
  );

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .CNT_W(4)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .taps         (taps),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .locked       (s_locked),
    .err_pulse    (s_err_pulse),
    .err_count    (s_err_count),
    .sample_count (s_sample_count),
    .state_o      (s_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are settled when this returns.
  task automatic step(input logic v, input logic [7:0] d, input logic c = 1'b0);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  // Generator model used only to produce the long saturation stream.
  function automatic logic [7:0] gen_next(input logic [7:0] s, input logic [7:0] t);
    return {^(s & t), s[7:1]};
  endfunction

  logic [7:0] s;

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; taps = 8'h1D;
    in_valid = 1'b0; in_data = 8'h00;

    @(posedge clk); #1;
    check("rst_state",  state_o, 0);
    check("rst_locked", locked, 0);
    check("rst_pulse",  err_pulse, 0);
    check("rst_errcnt", err_count, 0);
    check("rst_smpcnt", sample_count, 0);

    @(negedge clk); reset = 1'b0; enable = 1'b1;

    // Lock acquisition: 01 seeds, 80 40 20 10 are the four matches.
    step(1, 8'h01); check("seed_state", state_o, 1);
    step(1, 8'h80);
    step(1, 8'h40);
    step(1, 8'h20); check("pre_lock", locked, 0);
    step(1, 8'h10);
    check("lock_locked", locked, 1);
    check("lock_state",  state_o, 2);
    check("lock_errcnt", err_count, 0);

    // Single corrupted sample: expected 88, sent 89; flywheel keeps C4, E2 correct.
    step(1, 8'h89);
    check("single_pulse",  err_pulse, 1);
    check("single_errcnt", err_count, 1);
    step(1, 8'hC4); check("fly_pulse0", err_pulse, 0);
    step(1, 8'hE2); check("fly_pulse1", err_pulse, 0);
    check("fly_locked", locked, 1);
    check("fly_errcnt", err_count, 1);
    check("fly_smpcnt", sample_count, 3);

    // Clear with no sample in flight.
    step(0, 8'h00, 1'b1);
    check("clr_errcnt", err_count, 0);
    check("clr_smpcnt", sample_count, 0);
    check("clr_locked", locked, 1);

    // Loss of lock: expected 71 38 1C, sent 00 55 AA.
    step(1, 8'h00); check("loss_pulse0", err_pulse, 1); check("loss_lk0", locked, 1);
    step(1, 8'h55); check("loss_pulse1", err_pulse, 1); check("loss_lk1", locked, 1);
    step(1, 8'hAA); check("loss_pulse2", err_pulse, 1);
    check("loss_errcnt", err_count, 3);
    check("loss_locked", locked, 0);
    check("loss_state",  state_o, 1);

    // Relock from reseed AA: D5 EA F5 FA.
    step(1, 8'hD5);
    step(1, 8'hEA);
    step(1, 8'hF5); check("relock_pre", locked, 0);
    step(1, 8'hFA);
    check("relock_locked", locked, 1);
    check("relock_smpcnt", sample_count, 3);

    // Stall gaps while locked: nothing moves.
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00);
      check("gap_state",  state_o, 2);
      check("gap_pulse",  err_pulse, 0);
      check("gap_smpcnt", sample_count, 3);
    end
    step(1, 8'h7D);
    check("post_gap_pulse",  err_pulse, 0);
    check("post_gap_smpcnt", sample_count, 4);

    // Clear on the same cycle as a mismatch (expected 3E, sent 00).
    step(1, 8'h00, 1'b1);
    check("clrmis_pulse",  err_pulse, 1);
    check("clrmis_errcnt", err_count, 0);
    check("clrmis_smpcnt", sample_count, 0);
    step(1, 8'h9F);
    check("after_clr_pulse",  err_pulse, 0);
    check("after_clr_smpcnt", sample_count, 1);

    // enable low returns to IDLE.
    @(negedge clk); enable = 1'b0;
    step(0, 8'h00);
    check("dis_state", state_o, 0);
    @(negedge clk); enable = 1'b1;

    // Zero lockup: an all-zero stream never locks.
    step(1, 8'h00); check("zero_seed", state_o, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h00);
      check("zero_state", state_o, 1);
      check("zero_pulse", err_pulse, 0);
    end

    // Relock from SYNC, take one error, then assert reset mid-lock.
    step(1, 8'h01);
    step(1, 8'h80);
    step(1, 8'h40);
    step(1, 8'h20);
    step(1, 8'h10);
    check("rl2_locked", locked, 1);
    step(1, 8'h00);
    check("rl2_errcnt", err_count, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_state",  state_o, 0);
    check("arst_errcnt", err_count, 0);
    check("arst_smpcnt", sample_count, 0);
    @(posedge clk); @(negedge clk); reset = 1'b0;
    step(0, 8'h00);
    check("arst_idle", state_o, 0);

    // Saturation on the 4-bit instance: lock, then 20 isolated errors.
    s = 8'h01;
    step(1, s);
    for (int i = 0; i < 4; i++) begin
      s = gen_next(s, 8'h1D);
      step(1, s);
    end
    check("sat_locked0", s_locked, 1);
    for (int i = 0; i < 20; i++) begin
      s = gen_next(s, 8'h1D);
      step(1, s ^ 8'h01);
      if (i == 13) check("sat_err14", s_err_count, 14);
      if (i == 14) check("sat_err15", s_err_count, 15);
      s = gen_next(s, 8'h1D);
      step(1, s);
    end
    check("sat_errcnt", s_err_count, 15);
    check("sat_smpcnt", s_sample_count, 15);
    check("sat_locked", s_locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
